brief_rotation_sequencer: RTL and testbench
===========================================

Name: brief_rotation_sequencer

Overview:
- Upstream feeder of the rotation add/subtract stage in the rotated-BRIEF path.
- On a start pulse it latches one keypoint's cos/sin and walks the BRIEF sampling-pattern ROM, one point per cycle.
- For each point it forms the four rotation products x·cos, x·sin, y·cos and y·sin in the fixed-point format the add/subtract stage consumes.
- Results leave on a valid/ready stream; the pipeline stalls on back-pressure.

Parameters:
- BW_PAT, 6: signed width of pattern coordinates (integers, range -15..15).
- BW_TRIG, 8: signed width of cos/sin, Q1.6 (+64 = +1.0, -64 = -1.0).
- FRAC_TRIG, 6: fraction bits of cos/sin.
- BW_XCOS, 9: signed product output width; 6 integer bits including sign, BW_XCOS-6 fraction bits.
- NUM_POINTS, 512: pattern points per keypoint (256 pairs × 2).
- BW_ADDR, 9: pattern ROM address width (clog2 of NUM_POINTS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- cos_in  in  BW_TRIG  signed cos(theta), sampled with an accepted start.
- sin_in  in  BW_TRIG  signed sin(theta), sampled with an accepted start.
- pattern_addr  out  BW_ADDR  ROM address.
- pattern_en  out  1  ROM read enable. The ROM is synchronous: its data reflects the address of the last enabled cycle.
- pattern_x  in  BW_PAT  signed x from ROM, valid one cycle after the enabled read.
- pattern_y  in  BW_PAT  signed y from ROM, same timing as pattern_x.
- x11  out  BW_XCOS  x·cos.
- x12  out  BW_XCOS  x·sin.
- y11  out  BW_XCOS  y·cos.
- y12  out  BW_XCOS  y·sin.
- point_idx  out  BW_ADDR  index of the point carried by the current output.
- out_valid  out  1  output bus holds a valid point.
- out_ready  in  1  downstream accepts the output this cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last point is accepted.

Behaviour:
- Reset: all outputs 0, state IDLE, internal valids 0. Reset may assert mid-run; it aborts the run immediately, and no done pulse follows.
- FSM states:
  - IDLE → RUN on start. The same edge latches cos_in/sin_in and loads the address counter with 0.
  - RUN: issues addresses 0..NUM_POINTS-1. After issuing NUM_POINTS-1, go to DRAIN.
  - DRAIN: waits until the final point is accepted (out_valid && out_ready with point_idx = NUM_POINTS-1). Then pulse done and return to IDLE.
- start outside IDLE is ignored: latched cos/sin stay unchanged and the counter is not reset.
- Global advance enable: adv = !out_valid || out_ready.
  - pattern_en = adv && state==RUN.
  - The address increments only when pattern_en is high.
  - While adv=0 every pipeline register holds, pattern_addr holds, and the ROM output holds.
- Pipeline (no stall):
  - cycle 0: start accepted.
  - cycle 1: pattern_addr=0, pattern_en=1.
  - cycle 2: ROM data for point 0.
  - cycle 3: out_valid=1 with point 0.
  - Then one point per cycle; the last output appears at cycle NUM_POINTS+2.
- Arithmetic:
  - Full product p = coord × trig, signed, BW_PAT+BW_TRIG bits, FRAC_TRIG fraction bits.
  - Output = p arithmetically shifted right by FRAC_TRIG-(BW_XCOS-6), then truncated to BW_XCOS bits. This is floor rounding.
  - No saturation: |coord|≤15 and |trig|≤1.0 guarantee the value fits 6 integer bits.
- Output bus, point_idx and out_valid are registered. They change only when adv=1.
- Simultaneous events:
  - start arriving in the same cycle done pulses is ignored. A new run needs start in IDLE, one or more cycles after done.
  - out_ready while out_valid=0 is a don't-care.

Decomposition:
- Package orb_rot_pkg holds:
  - the BW_PAT, BW_TRIG, FRAC_TRIG, BW_XCOS and NUM_POINTS defaults;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the constant OUT_SHIFT = FRAC_TRIG-(BW_XCOS-6).
- One sub-module: rot_mult4. It performs the four signed multiplies plus the shift/truncate, with a register stage gated by adv.

Test Plan:
- cos=64, sin=0; ROM point0=(5,-3) → x11=40, x12=0, y11=-24, y12=0 (raw; 3 fraction bits); out_valid in cycle 3.
- cos=0, sin=64; point (-15,15) → x11=0, x12=-120, y11=0, y12=120.
- cos=sin=45; points (15,-15) → x11=84, x12=84, y11=-85, y12=-85 (floor rounding on negatives).
- out_ready held low for 5 cycles mid-run → pattern_addr, outputs and point_idx frozen. After release, no point is skipped or duplicated, and point_idx stays contiguous.
- Full run with out_ready=1 → exactly 512 valid outputs, point_idx 0..511, done pulse one cycle after point 511; start pulses issued during busy have no effect.
- Reset asserted at point 200 → all outputs 0 immediately, no done pulse; a subsequent start restarts cleanly at point 0.

Source files
------------

// File: rtl/orb_rot_pkg.sv
// rtl/orb_rot_pkg.sv - shared widths, FSM state type and output shift for the rotation sequencer
package orb_rot_pkg;

    localparam int BW_PAT     = 6;    // signed pattern coordinate width
    localparam int BW_TRIG    = 8;    // signed cos/sin width, Q1.6
    localparam int FRAC_TRIG  = 6;    // fraction bits of cos/sin
    localparam int BW_XCOS    = 9;    // product width: 6 integer bits + 3 fraction bits
    localparam int NUM_POINTS = 512;  // pattern points per keypoint

    // Right shift taking the full product (FRAC_TRIG fraction bits) down to
    // the BW_XCOS-6 fraction bits the add/subtract stage expects.
    localparam int OUT_SHIFT = FRAC_TRIG - (BW_XCOS - 6);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rot_state_e;

endpackage

// File: rtl/rot_mult4.sv
// rtl/rot_mult4.sv - four signed coordinate x trig products with floor shift, registered under adv
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   adv               pipeline advance; registers hold while low
//   cos_val, sin_val  latched keypoint cos/sin (Q1.6)
//   coord_x, coord_y  pattern point from the ROM
//   x11, x12          x*cos, x*sin
//   y11, y12          y*cos, y*sin
module rot_mult4 import orb_rot_pkg::*; #(
    parameter int BW_PAT  = orb_rot_pkg::BW_PAT,
    parameter int BW_TRIG = orb_rot_pkg::BW_TRIG,
    parameter int BW_XCOS = orb_rot_pkg::BW_XCOS,
    parameter int SHIFT   = orb_rot_pkg::OUT_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       adv,
    input  logic signed [BW_TRIG-1:0]  cos_val,
    input  logic signed [BW_TRIG-1:0]  sin_val,
    input  logic signed [BW_PAT-1:0]   coord_x,
    input  logic signed [BW_PAT-1:0]   coord_y,
    output logic signed [BW_XCOS-1:0]  x11,
    output logic signed [BW_XCOS-1:0]  x12,
    output logic signed [BW_XCOS-1:0]  y11,
    output logic signed [BW_XCOS-1:0]  y12
);

    localparam int PW = BW_PAT + BW_TRIG;

    // Arithmetic shift of a signed product floors toward -inf; the value is
    // bounded by |coord|<=15, |trig|<=1.0 so truncation never wraps.
    function automatic logic signed [BW_XCOS-1:0] rot_scale(
        input logic signed [BW_PAT-1:0]  c,
        input logic signed [BW_TRIG-1:0] t
    );
        logic signed [PW-1:0] p;
        p = PW'(c) * PW'(t);
        return BW_XCOS'(p >>> SHIFT);
    endfunction

    logic signed [BW_XCOS-1:0] x11_d, x11_q;
    logic signed [BW_XCOS-1:0] x12_d, x12_q;
    logic signed [BW_XCOS-1:0] y11_d, y11_q;
    logic signed [BW_XCOS-1:0] y12_d, y12_q;

    always_comb begin
        x11_d = x11_q;
        x12_d = x12_q;
        y11_d = y11_q;
        y12_d = y12_q;
        if (adv) begin
            x11_d = rot_scale(coord_x, cos_val);
            x12_d = rot_scale(coord_x, sin_val);
            y11_d = rot_scale(coord_y, cos_val);
            y12_d = rot_scale(coord_y, sin_val);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x11_q <= '0;
            x12_q <= '0;
            y11_q <= '0;
            y12_q <= '0;
        end else begin
            x11_q <= x11_d;
            x12_q <= x12_d;
            y11_q <= y11_d;
            y12_q <= y12_d;
        end
    end

    assign x11 = x11_q;
    assign x12 = x12_q;
    assign y11 = y11_q;
    assign y12 = y12_q;

endmodule

// File: rtl/brief_rotation_sequencer.sv
// rtl/brief_rotation_sequencer.sv - walks the BRIEF pattern ROM and streams rotation products per point
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle run request, honoured only in IDLE
//   cos_in, sin_in            keypoint orientation, latched with an accepted start
//   pattern_addr, pattern_en  synchronous ROM read port
//   pattern_x, pattern_y      ROM data, valid one cycle after an enabled read
//   x11, x12, y11, y12        x*cos, x*sin, y*cos, y*sin
//   point_idx                 point index carried by the output bus
//   out_valid, out_ready      output handshake
//   busy                      run in progress
//   done                      pulse after the last point is accepted
module brief_rotation_sequencer import orb_rot_pkg::*; #(
    parameter int BW_PAT     = orb_rot_pkg::BW_PAT,
    parameter int BW_TRIG    = orb_rot_pkg::BW_TRIG,
    parameter int FRAC_TRIG  = orb_rot_pkg::FRAC_TRIG,
    parameter int BW_XCOS    = orb_rot_pkg::BW_XCOS,
    parameter int NUM_POINTS = orb_rot_pkg::NUM_POINTS,
    parameter int BW_ADDR    = $clog2(NUM_POINTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [BW_TRIG-1:0]  cos_in,
    input  logic signed [BW_TRIG-1:0]  sin_in,
    output logic [BW_ADDR-1:0]         pattern_addr,
    output logic                       pattern_en,
    input  logic signed [BW_PAT-1:0]   pattern_x,
    input  logic signed [BW_PAT-1:0]   pattern_y,
    output logic signed [BW_XCOS-1:0]  x11,
    output logic signed [BW_XCOS-1:0]  x12,
    output logic signed [BW_XCOS-1:0]  y11,
    output logic signed [BW_XCOS-1:0]  y12,
    output logic [BW_ADDR-1:0]         point_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam logic [BW_ADDR-1:0] LAST_IDX = BW_ADDR'(NUM_POINTS - 1);

    rot_state_e                state_d, state_q;
    logic signed [BW_TRIG-1:0] cos_d, cos_q;
    logic signed [BW_TRIG-1:0] sin_d, sin_q;
    logic [BW_ADDR-1:0]        addr_d, addr_q;
    logic                      rom_vld_d, rom_vld_q;   // ROM output holds a requested point
    logic [BW_ADDR-1:0]        rom_idx_d, rom_idx_q;   // index of that point
    logic                      out_valid_d, out_valid_q;
    logic [BW_ADDR-1:0]        point_idx_d, point_idx_q;
    logic                      busy_d, busy_q;
    logic                      done_d, done_q;

    logic adv;
    logic rd_en;
    logic start_ok;
    logic last_acc;

    // Whole pipeline moves together: it advances whenever the output slot is
    // empty or being consumed, so a stall freezes ROM, products and index.
    assign adv   = !out_valid_q || out_ready;
    assign rd_en = adv && (state_q == RUN);

    // done_q is high only in the IDLE cycle right after a run; a start there
    // would overlap the completion pulse and is dropped.
    assign start_ok = start && (state_q == IDLE) && !done_q;
    assign last_acc = out_valid_q && out_ready && (point_idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        addr_d      = addr_q;
        rom_vld_d   = rom_vld_q;
        rom_idx_d   = rom_idx_q;
        out_valid_d = out_valid_q;
        point_idx_d = point_idx_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cos_d   = cos_in;
                    sin_d   = sin_in;
                    addr_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    if (addr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + BW_ADDR'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_acc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            rom_vld_d   = rd_en;
            rom_idx_d   = addr_q;
            out_valid_d = rom_vld_q;
            point_idx_d = rom_idx_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cos_q       <= '0;
            sin_q       <= '0;
            addr_q      <= '0;
            rom_vld_q   <= 1'b0;
            rom_idx_q   <= '0;
            out_valid_q <= 1'b0;
            point_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            addr_q      <= addr_d;
            rom_vld_q   <= rom_vld_d;
            rom_idx_q   <= rom_idx_d;
            out_valid_q <= out_valid_d;
            point_idx_q <= point_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    rot_mult4 #(
        .BW_PAT  (BW_PAT),
        .BW_TRIG (BW_TRIG),
        .BW_XCOS (BW_XCOS),
        .SHIFT   (FRAC_TRIG - (BW_XCOS - 6))
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .cos_val (cos_q),
        .sin_val (sin_q),
        .coord_x (pattern_x),
        .coord_y (pattern_y),
        .x11     (x11),
        .x12     (x12),
        .y11     (y11),
        .y12     (y12)
    );

    assign pattern_addr = addr_q;
    assign pattern_en   = rd_en;
    assign point_idx    = point_idx_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_brief_rotation_sequencer.sv
// tb/tb_brief_rotation_sequencer.sv - directed self-checking bench for brief_rotation_sequencer
module tb_brief_rotation_sequencer;

    localparam int NPTS = 512;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [7:0] cos_in;
    logic signed [7:0] sin_in;
    logic [8:0]        pattern_addr;
    logic              pattern_en;
    logic signed [5:0] pattern_x;
    logic signed [5:0] pattern_y;
    logic signed [8:0] x11, x12, y11, y12;
    logic [8:0]        point_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    brief_rotation_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cos_in       (cos_in),
        .sin_in       (sin_in),
        .pattern_addr (pattern_addr),
        .pattern_en   (pattern_en),
        .pattern_x    (pattern_x),
        .pattern_y    (pattern_y),
        .x11          (x11),
        .x12          (x12),
        .y11          (y11),
        .y12          (y12),
        .point_idx    (point_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int px(input int a);
        case (a)
            0:       return 5;
            1:       return -15;
            2:       return 15;
            default: return (a % 31) - 15;
        endcase
    endfunction

    function automatic int py(input int a);
        case (a)
            0:       return -3;
            1:       return 15;
            2:       return -15;
            default: return 15 - ((a * 7) % 31);
        endcase
    endfunction

    // floor(coord*trig / 8)
    function automatic int expv(input int coord, input int trig);
        int p;
        p = coord * trig;
        if (p >= 0) return p / 8;
        return -((-p + 7) / 8);
    endfunction

    // Synchronous pattern ROM
    initial begin
        pattern_x = '0;
        pattern_y = '0;
    end
    always @(posedge clk) begin
        if (pattern_en) begin
            pattern_x <= 6'(px(int'(pattern_addr)));
            pattern_y <= 6'(py(int'(pattern_addr)));
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input int idx, input int c, input int s);
        check({tag, "_x11"}, x11, expv(px(idx), c));
        check({tag, "_x12"}, x12, expv(px(idx), s));
        check({tag, "_y11"}, y11, expv(py(idx), c));
        check({tag, "_y12"}, y12, expv(py(idx), s));
    endtask

    // Issue start at a negedge, then check the fixed 3-cycle latency to point 0.
    task automatic launch(input int c, input int s);
        cos_in = 8'(c);
        sin_in = 8'(s);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cos_in = 8'sd7;
        sin_in = -8'sd7;
        check("c1_pattern_en", pattern_en, 1);
        check("c1_addr", pattern_addr, 0);
        check("c1_busy", busy, 1);
        check("c1_out_valid", out_valid, 0);
        @(negedge clk);
        check("c2_out_valid", out_valid, 0);
        check("c2_addr", pattern_addr, 1);
        @(negedge clk);
        check("c3_out_valid", out_valid, 1);
        check("c3_point_idx", point_idx, 0);
    endtask

    task automatic stream(input int c, input int s, input int stall_pt, input int abort_pt,
                          input int dir_pt, input int d0, input int d1, input int d2, input int d3,
                          output int n_acc, output bit saw_done);
        int  e;
        bit  prev_last;
        bit  stalled;
        bit  busy_started;
        e = 0;
        prev_last = 0;
        stalled = 0;
        busy_started = 0;
        saw_done = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = 1'b0;
            if (done) begin
                check("done_follows_last", prev_last, 1);
                saw_done = 1;
                cos_in = 8'sd10;
                sin_in = -8'sd10;
                start  = 1'b1;
                @(negedge clk);
                start  = 1'b0;
                check("done_one_cycle", done, 0);
                check("start_with_done_ignored", busy, 0);
                break;
            end
            prev_last = 0;
            if (abort_pt >= 0 && e == abort_pt) begin
                rst = 1'b1;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_x11", x11, 0);
                check("abort_x12", x12, 0);
                check("abort_y11", y11, 0);
                check("abort_y12", y12, 0);
                check("abort_point_idx", point_idx, 0);
                check("abort_addr", pattern_addr, 0);
                check("abort_pattern_en", pattern_en, 0);
                check("abort_busy", busy, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                break;
            end
            if (!stalled && stall_pt >= 0 && out_valid && point_idx == 9'(stall_pt)) begin
                stalled = 1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_point_idx", point_idx, stall_pt);
                    check("stall_addr", pattern_addr, stall_pt + 2);
                    check("stall_pattern_en", pattern_en, 0);
                    check_bus("stall", stall_pt, c, s);
                end
                out_ready = 1'b1;
            end
            if (!busy_started && e == 50) begin
                busy_started = 1;
                cos_in = -8'sd64;
                sin_in = 8'sd64;
                start  = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("point_idx", point_idx, e);
                check_bus("pt", e, c, s);
                if (e == dir_pt) begin
                    check("dir_x11", x11, d0);
                    check("dir_x12", x12, d1);
                    check("dir_y11", y11, d2);
                    check("dir_y12", y12, d3);
                end
                if (e == NPTS - 1) prev_last = 1;
                e++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_acc = e;
    endtask

    initial begin
        int n;
        bit sd;
        rst       = 1'b1;
        start     = 1'b0;
        cos_in    = '0;
        sin_in    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pattern_en", pattern_en, 0);
        check("rst_addr", pattern_addr, 0);
        check("rst_x11", x11, 0);
        check("rst_point_idx", point_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_pattern_en", pattern_en, 0);
        out_ready = 1'b1;

        // cos=1.0, sin=0, stall at point 100, start during busy
        launch(64, 0);
        stream(64, 0, 100, -1, 0, 40, 0, -24, 0, n, sd);
        check("runA_count", n, NPTS);
        check("runA_done", sd, 1);

        // cos=0, sin=1.0, reset mid-run at point 200
        @(negedge clk);
        launch(0, 64);
        stream(0, 64, -1, 200, 1, 0, -120, 0, 120, n, sd);
        check("runB_count", n, 200);
        check("runB_done", sd, 0);

        // cos=sin=45, negative floor rounding, clean restart after reset
        @(negedge clk);
        launch(45, 45);
        stream(45, 45, -1, -1, 2, 84, 84, -85, -85, n, sd);
        check("runC_count", n, NPTS);
        check("runC_done", sd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
